// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, MSB-first data, optional even parity, stop bit.
// Good words land in a one-entry holding register behind a valid/ready handshake.
module serial_frame_rx #(
  parameter int unsigned DATA_W    = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdi,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned      CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              par_bad;

  // Even parity over data plus the parity bit must reduce to zero.
  assign par_bad = PARITY_EN && ((^shift_q) ^ par_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (sdi) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        shift_d = {shift_q[DATA_W-2:0], sdi};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        par_d   = sdi;
        state_d = StStop;
      end
      StStop: begin
        // A 1 here is a framing error, never a fresh start bit.
        state_d = StIdle;
        if (sdi) begin
          ferr_d = 1'b1;
        end else if (par_bad) begin
          perr_d = 1'b1;
        end else if (valid_q && !out_ready) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != StIdle);
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
